uart_tx_module: RTL and testbench
=================================

# uart_tx_module

UART 8N1 transmitter that serialises a word of DEPTH bytes onto a single `tx` line at `boadrate`. It accepts one word per valid/ready handshake and sends it LSB-first, byte 0 first. It is the transmit-side counterpart of `uart_rx_module`: its `tx` output drives that block's `rx` input in loopback, and the received `data` equals the sent `data`.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `boadrate`, default 115200: line rate in bit/s.
- `DEPTH`, default 4: bytes per word; must be ≥ 1.
- `clk`  input  1: system clock. One clock domain; all logic on its rising edge.
- `arstn`  input  1: reset, asynchronous and active-low.
- `data`  input  [DEPTH-1:0][7:0]: word to send. Byte 0 goes first.
- `valid`  input  1: `data` is valid.
- `ready`  output  1: block is idle and will accept a word.
- `tx`  output  1: serial line. Idles high.
- `busy`  output  1: high from acceptance until the last stop bit completes.

## Operation
- `CLKS_PER_BIT = CLK_FREQ / boadrate`, using integer division (434 at the defaults). Elaboration fails if `CLKS_PER_BIT < 2`.
- Handshake: a word is accepted on the rising edge where `valid && ready`.
  - The whole word is latched into an internal shift register at that edge.
  - Later changes on `data` and `valid` are ignored until `ready` returns.
  - There is no queue. `valid` while `busy` is dropped, not stalled.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on acceptance.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 8 bits of CLKS_PER_BIT cycles each.
  - STOP → START if more bytes remain, otherwise STOP → IDLE.
- `tx` per state:
  - 1 in IDLE.
  - 0 in START.
  - Current byte bit in DATA, bit 0 first.
  - 1 in STOP.
- Bytes within one word are back-to-back, with no idle gap between a stop bit and the next start bit.
- Counters:
  - Baud counter, width `$clog2(CLKS_PER_BIT)`, counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - Bit index, 3 bits.
  - Byte index, width `max(1,$clog2(DEPTH))`, counts 0..DEPTH-1.
  - Byte index wraps to 0 when the word is done; no counter ever overflows past its terminal value.
- `tx`, `ready` and `busy` are registered outputs (no combinational path from inputs).
- Reset values: `tx`=1, `ready`=1, `busy`=0, state IDLE, all counters 0.
- Reset mid-frame: `tx` goes to 1 asynchronously, the word in progress is abandoned, and after release the block is IDLE with `ready`=1.

## Timing
- Acceptance edge T:
  - `ready` falls at T.
  - `busy` rises at T.
  - `tx` falls at T (start bit begins the first cycle after acceptance).
- Every bit lasts exactly CLKS_PER_BIT cycles. One byte lasts 10·CLKS_PER_BIT cycles.
- Word duration is DEPTH·10·CLKS_PER_BIT cycles from the first start-bit cycle. At the defaults this is 4·10·434 = 17360 cycles.
- At the edge ending the last stop bit:
  - `busy` falls and `ready` rises.
  - A new word can be accepted on that same edge's successor, so the minimum idle gap between words is 1 cycle of `tx`=1.
- `valid` held high continuously sends words back-to-back, with that 1-cycle gap between them.

## Structure
- Shared package `uart_pkg` holds:
  - The `uart_state_t` enum (IDLE/START/DATA/STOP), shared with `uart_rx_module`.
  - The constant `CLK_FREQ_DEFAULT = 50_000_000`.
  - The function `clks_per_bit(clk_freq, baud)`.
- One sub-module, `uart_baud_tick`:
  - Parameter CLKS_PER_BIT.
  - Inputs `clk`, `arstn`, `en`.
  - Output `tick`: pulses 1 cycle every CLKS_PER_BIT cycles while `en`; the counter clears when `en` is low.
  - The same sub-module is reusable on the receive side.

## Test plan
- Reset idle: hold `arstn`=0 for 3 cycles, then release → `tx`=1, `ready`=1, `busy`=0; no `tx` edge for 1000 cycles.
- Single word waveform: `data`={8'hF0,8'hF0,8'hF0,8'h55}, 1-cycle `valid`.
  - Start bit begins 1 cycle after acceptance.
  - First byte on `tx` is 0,1,0,1,0,1,0,1,0,1, each bit 434 cycles.
  - Then three bytes 0,0,0,0,0,1,1,1,1,1.
  - `busy` is high for exactly 17360 cycles.
- Loopback: `tx` drives `uart_rx_module.rx` (same parameters) → receiver `valid` pulses once, with `data` = {F0,F0,F0,55}.
- Ignored input: pulse `valid` with `data`=32'hDEADBEEF mid-word → the transmitted word is unchanged and no second word is sent.
- Back-to-back: `valid` held high with two different words → both are sent in order, separated by exactly 1 idle-high cycle.
- Reset mid-frame: drop `arstn` during DATA of byte 1 → `tx`=1 immediately; after release `ready`=1, and a fresh word transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive blocks.
package uart_pkg;

   // Line-side FSM states; the receiver walks the same sequence.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int CLK_FREQ_DEFAULT = 50_000_000;

   // Whole system clocks per line bit (truncating division).
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles while enabled.
// The count is held at zero whenever en is low, so the first tick after
// en rises lands exactly CLKS_PER_BIT cycles later.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic arstn,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   // Free-running 0..CLKS_PER_BIT-1 counter, cleared while disabled.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn)                     cnt <= '0;
      else if (!en || (cnt == LAST))  cnt <= '0;
      else                            cnt <= cnt + 1'b1;
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_module.sv
// UART 8N1 transmitter: one DEPTH-byte word per valid/ready handshake,
// byte 0 first, each byte LSB first, bytes back-to-back within a word.
module uart_tx_module
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = CLK_FREQ_DEFAULT,
   parameter int boadrate = 115200,
   parameter int DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  arstn,
   input  logic [DEPTH-1:0][7:0] data,
   input  logic                  valid,
   output logic                  ready,
   output logic                  tx,
   output logic                  busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, boadrate);
   localparam int BW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(DEPTH - 1);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_START = START;
   localparam logic [1:0] S_DATA  = DATA;
   localparam logic [1:0] S_STOP  = STOP;

   // Refuse to build with a bit period the timer cannot represent.
   if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx_module: CLK_FREQ / boadrate must be at least 2");
   end
   if (DEPTH < 1) begin : g_bad_depth
      $error("uart_tx_module: DEPTH must be at least 1");
   end

   logic [1:0]         state;
   logic [2:0]         bit_idx;
   logic [BW-1:0]      byte_idx;
   logic [DEPTH*8-1:0] shreg;
   logic               tick;

   logic accept;
   logic start_done;
   logic data_step;
   logic data_done;
   logic stop_done;
   logic word_done;

   assign accept     = (state == S_IDLE) && valid && ready;
   assign start_done = (state == S_START) && tick;
   assign data_step  = (state == S_DATA) && tick && (bit_idx != 3'd7);
   assign data_done  = (state == S_DATA) && tick && (bit_idx == 3'd7);
   assign stop_done  = (state == S_STOP) && tick;
   assign word_done  = stop_done && (byte_idx == LAST_BYTE);

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .arstn (arstn),
      .en    (state != S_IDLE),
      .tick  (tick)
   );

   // Frame sequencing and bit/byte position tracking.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state    <= S_IDLE;
         bit_idx  <= '0;
         byte_idx <= '0;
      end else begin
         case (state)
            S_IDLE:  if (accept) state <= S_START;
            S_START: if (start_done) state <= S_DATA;
            S_DATA: begin
               if (data_done) begin
                  bit_idx <= '0;
                  state   <= S_STOP;
               end else if (data_step) begin
                  bit_idx <= bit_idx + 3'd1;
               end
            end
            S_STOP: begin
               if (word_done) begin
                  byte_idx <= '0;
                  state    <= S_IDLE;
               end else if (stop_done) begin
                  byte_idx <= byte_idx + 1'b1;
                  state    <= S_START;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Word shifter: latched on accept, shifted once per data bit driven,
   // so the next byte's bit 0 sits at the bottom when its start bit ends.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn)                       shreg <= '0;
      else if (accept)                  shreg <= data;
      else if (start_done || data_step) shreg <= shreg >> 1;
   end

   // Registered line and handshake outputs.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         tx    <= 1'b1;
         ready <= 1'b1;
         busy  <= 1'b0;
      end else begin
         if (accept) begin
            tx    <= 1'b0;
            ready <= 1'b0;
            busy  <= 1'b1;
         end else if (start_done || data_step) begin
            tx <= shreg[0];
         end else if (data_done) begin
            tx <= 1'b1;
         end else if (word_done) begin
            ready <= 1'b1;
            busy  <= 1'b0;
         end else if (stop_done) begin
            tx <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_module.sv
// Directed bench for uart_tx_module at 10 clocks per bit, 4-byte words.
module tb_uart_tx_module;

   localparam int N     = 10;
   localparam int DEPTH = 4;
   localparam int BITS  = DEPTH * 10;

   logic                  clk;
   logic                  arstn;
   logic [DEPTH-1:0][7:0] data;
   logic                  valid;
   logic                  ready;
   logic                  tx;
   logic                  busy;

   int n_tests;
   int n_fail;

   uart_tx_module #(
      .CLK_FREQ (50_000_000),
      .boadrate (5_000_000),
      .DEPTH    (DEPTH)
   ) dut (
      .clk   (clk),
      .arstn (arstn),
      .data  (data),
      .valid (valid),
      .ready (ready),
      .tx    (tx),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected line level for frame bit b of word w: start 0, 8 data LSB first, stop 1.
   function automatic logic exp_bit(input logic [31:0] w, input int b);
      int p;
      p = b % 10;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return w[(b / 10) * 8 + p - 1];
   endfunction

   // Entered on the first start-bit cycle; leaves on the first cycle after
   // the last stop bit. Optionally pulses valid with junk at cycle inject_at.
   task automatic check_word(input logic [31:0] w, input int inject_at, input string tag);
      int          bad;
      int          busy_cnt;
      int          cyc;
      logic [31:0] rx;
      busy_cnt = 0;
      rx       = '0;
      for (int b = 0; b < BITS; b++) begin
         bad = 0;
         for (int c = 0; c < N; c++) begin
            cyc = b * N + c;
            if (tx !== exp_bit(w, b)) bad++;
            if (busy === 1'b1) busy_cnt++;
            if ((c == N / 2) && (b % 10 >= 1) && (b % 10 <= 8))
               rx[(b / 10) * 8 + (b % 10) - 1] = tx;
            if (cyc == inject_at) begin
               data  = 32'hDEADBEEF;
               valid = 1'b1;
            end else if ((inject_at >= 0) && (cyc == inject_at + 1)) begin
               valid = 1'b0;
            end
            @(negedge clk);
         end
         chk($sformatf("%s bit%0d bad cycles", tag, b), bad, 0);
      end
      chk($sformatf("%s busy cycles", tag), busy_cnt, BITS * N);
      chk($sformatf("%s decoded word", tag), rx, w);
      chk($sformatf("%s ready after", tag), ready, 1'b1);
      chk($sformatf("%s busy after", tag), busy, 1'b0);
   endtask

   task automatic idle_check(input int cycles, input string tag);
      int bad;
      bad = 0;
      repeat (cycles) begin
         if ((tx !== 1'b1) || (busy !== 1'b0)) bad++;
         @(negedge clk);
      end
      chk(tag, bad, 0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      arstn   = 1'b0;
      valid   = 1'b0;
      data    = '0;

      // Reset and idle
      repeat (3) @(negedge clk);
      chk("reset tx", tx, 1'b1);
      chk("reset ready", ready, 1'b1);
      chk("reset busy", busy, 1'b0);
      arstn = 1'b1;
      @(negedge clk);
      chk("post-reset tx", tx, 1'b1);
      chk("post-reset ready", ready, 1'b1);
      idle_check(1000, "idle 1000 cycles");

      // Single word, 1-cycle valid
      data  = {8'hF0, 8'hF0, 8'hF0, 8'h55};
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      chk("w1 ready low", ready, 1'b0);
      chk("w1 busy high", busy, 1'b1);
      chk("w1 start bit", tx, 1'b0);
      check_word(32'hF0F0F055, -1, "w1");

      // Mid-word valid with junk data is dropped
      repeat (5) @(negedge clk);
      data  = 32'h1234A50F;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      data  = 32'h0;
      check_word(32'h1234A50F, 150, "ign");
      idle_check(100, "ign no second word");

      // valid held high: two words with one idle cycle between
      data  = 32'hC33C817E;
      valid = 1'b1;
      @(negedge clk);
      data  = 32'h0180FF00;
      check_word(32'hC33C817E, -1, "b2b A");
      chk("b2b gap tx", tx, 1'b1);
      @(negedge clk);
      valid = 1'b0;
      chk("b2b B accepted", busy, 1'b1);
      check_word(32'h0180FF00, -1, "b2b B");
      idle_check(50, "b2b idle after");

      // Reset during byte 1 data bits
      data  = {8'hF0, 8'hF0, 8'hF0, 8'h55};
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      repeat (130) @(negedge clk);
      chk("mid-frame tx before reset", tx, 1'b0);
      #2 arstn = 1'b0;
      #1;
      chk("async reset tx", tx, 1'b1);
      chk("async reset ready", ready, 1'b1);
      chk("async reset busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      arstn = 1'b1;
      @(negedge clk);
      chk("post mid-reset ready", ready, 1'b1);
      idle_check(20, "post mid-reset idle");
      data  = 32'hA5C3E187;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      check_word(32'hA5C3E187, -1, "fresh");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
